// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S receive path.
package i2s_pkg;

  typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} i2s_ch_e;

  typedef enum logic {UNLOCKED = 1'b0, RUN = 1'b1} rx_state_e;

  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_WORD_MAX  = 64;

endpackage

// File: rtl/i2s_slave_rx_if.sv
// Parallel sample bus from the I2S receiver to the 32-bit sample latch.
interface i2s_slave_rx_if;
  import i2s_pkg::*;

  logic [I2S_SLOT_BITS-1:0] sample_dat;
  i2s_ch_e                  sample_ch;
  logic                     sample_vld;

  modport master (output sample_dat, sample_ch, sample_vld);
  modport slave  (input  sample_dat, sample_ch, sample_vld);

endinterface

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with an optional registered
// rising-edge strobe.
module sync_edge #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic lmmi_clk_i,
  input  logic reset_n_i,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [STAGES-1:0] sync_p0;

  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) sync_p0 <= '0;
    else            sync_p0 <= {sync_p0[STAGES-2:0], d};
  end

  assign q = sync_p0[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic q_p1;
    // Edge stage: rise lands one clock after the synchronized level changes.
    always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        q_p1 <= 1'b0;
        rise <= 1'b0;
      end else begin
        q_p1 <= q;
        rise <= q & ~q_p1;
      end
    end
  end else begin : g_no_edge
    assign rise = 1'b0;
  end

endmodule

// File: rtl/i2s_slave_rx.sv
// I2S slave receiver: oversamples SCK/WS/SD on the system clock and emits one
// sign-extended sample per slot with a single-cycle strobe.
module i2s_slave_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255,
  parameter int MAX_SLOT    = I2S_WORD_MAX
) (
  input  logic           lmmi_clk_i,
  input  logic           reset_n_i,
  input  logic           conf_en_i,
  input  logic           i2s_sck_i,
  input  logic           i2s_ws_i,
  input  logic           i2s_sd_i,
  i2s_slave_rx_if.master smp,
  output logic           locked_o,
  output logic           frame_err_o
);

  localparam int CNT_W = $clog2(MAX_SLOT + 2);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_SLOT);
  localparam logic [CNT_W-1:0] SAT_C   = CNT_W'(MAX_SLOT + 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  function automatic logic signed [I2S_SLOT_BITS-1:0] sign_ext(
    input logic signed [DATA_WIDTH-1:0] v);
    return I2S_SLOT_BITS'(v);
  endfunction

  logic sck_rise, ws_s, sd_s;
  logic sck_lvl_unused, ws_rise_unused, sd_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sck (
    .lmmi_clk_i(lmmi_clk_i), .reset_n_i(reset_n_i), .d(i2s_sck_i),
    .q(sck_lvl_unused), .rise(sck_rise));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_ws (
    .lmmi_clk_i(lmmi_clk_i), .reset_n_i(reset_n_i), .d(i2s_ws_i),
    .q(ws_s), .rise(ws_rise_unused));
  sync_edge #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sd (
    .lmmi_clk_i(lmmi_clk_i), .reset_n_i(reset_n_i), .d(i2s_sd_i),
    .q(sd_s), .rise(sd_rise_unused));

  rx_state_e                    state;
  logic                         ws_q;
  logic [CNT_W-1:0]             bit_cnt, cnt_inc;
  logic [TO_W-1:0]              to_cnt;
  logic signed [DATA_WIDTH-1:0] shift_p1, sh_next, word;
  logic                         ws_edge;

  assign ws_edge = (ws_s != ws_q);
  assign cnt_inc = (bit_cnt == SAT_C) ? bit_cnt : bit_cnt + 1'b1;
  assign sh_next = {shift_p1[DATA_WIDTH-2:0], sd_s};
  // Bits past DATA_WIDTH are slot padding, so the word freezes once full.
  assign word    = (bit_cnt < DW_C) ? sh_next : shift_p1;

  always_ff @(posedge lmmi_clk_i) begin
    if (sck_rise && (bit_cnt < DW_C)) shift_p1 <= sh_next;
  end

  // Framing stage: decisions are taken on sck_rise and registered here.
  always_ff @(posedge lmmi_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= UNLOCKED;
      ws_q           <= 1'b0;
      bit_cnt        <= '0;
      to_cnt         <= '0;
      smp.sample_dat <= '0;
      smp.sample_ch  <= LEFT;
      smp.sample_vld <= 1'b0;
      locked_o       <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      smp.sample_vld <= 1'b0;
      frame_err_o    <= 1'b0;
      if (sck_rise) ws_q <= ws_s;
      if (!conf_en_i) begin
        state    <= UNLOCKED;
        locked_o <= 1'b0;
        bit_cnt  <= '0;
        to_cnt   <= '0;
      end else begin
        case (state)
          UNLOCKED: begin
            to_cnt <= '0;
            if (sck_rise && ws_edge) begin
              state    <= RUN;
              locked_o <= 1'b1;
              bit_cnt  <= '0;
            end
          end
          RUN: begin
            if (sck_rise) begin
              to_cnt <= '0;
              if (ws_edge) begin
                bit_cnt <= '0;
                if (cnt_inc >= DW_C) begin
                  smp.sample_vld <= 1'b1;
                  smp.sample_dat <= sign_ext(word);
                  smp.sample_ch  <= i2s_ch_e'(ws_q);
                end else begin
                  frame_err_o <= 1'b1;
                end
              end else begin
                bit_cnt <= cnt_inc;
                if (cnt_inc > MAX_C) begin
                  frame_err_o <= 1'b1;
                  state       <= UNLOCKED;
                  locked_o    <= 1'b0;
                end
              end
            end else if (to_cnt == TO_LAST) begin
              frame_err_o <= 1'b1;
              state       <= UNLOCKED;
              locked_o    <= 1'b0;
              to_cnt      <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2s_slave_rx.sv
// Directed bench for i2s_slave_rx: table of stereo slots plus framing corner cases.
module tb_i2s_slave_rx;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic conf_en = 1'b0;
  logic sck = 1'b0;
  logic ws = 1'b0;
  logic sd = 1'b0;
  logic locked, ferr;

  i2s_slave_rx_if smp();

  i2s_slave_rx #(.DATA_WIDTH(24), .SYNC_STAGES(SYNC), .TIMEOUT(255), .MAX_SLOT(64)) dut (
    .lmmi_clk_i(clk), .reset_n_i(rst_n), .conf_en_i(conf_en),
    .i2s_sck_i(sck), .i2s_ws_i(ws), .i2s_sd_i(sd),
    .smp(smp), .locked_o(locked), .frame_err_o(ferr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0, err_cnt = 0, exp_err = 0, last_rise = 0;
  logic [31:0] q_dat[$];
  logic        q_ch[$];
  int          q_cyc[$];

  always @(negedge clk) begin
    if (smp.sample_vld) begin
      q_dat.push_back(smp.sample_dat);
      q_ch.push_back(smp.sample_ch);
      q_cyc.push_back(cyc);
    end
    if (ferr) err_cnt++;
  end

  typedef struct {
    logic        ch;
    logic [23:0] data;
    int          half;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic w, input logic d, input int half);
    @(negedge clk);
    sck = 1'b0; ws = w; sd = d;
    repeat (half) @(negedge clk);
    sck = 1'b1;
    last_rise = cyc;
    repeat (half - 1) @(negedge clk);
  endtask

  task automatic send_slot(input logic ch, input logic [23:0] data, input int half, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      logic w, d;
      w = (i == nbits - 1) ? ~ch : ch;
      d = (i < 24) ? data[23-i] : i[0];
      send_bit(w, d, half);
    end
  endtask

  task automatic expect_strobe(input string name, input logic ch, input logic [31:0] dat);
    int ec;
    ec = last_rise + SYNC + 2;
    repeat (4) @(negedge clk);
    if (q_dat.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: no strobe, expected ch %0d dat %h", name, ch, dat);
    end else begin
      chk({name, ".ch"}, 32'(q_ch.pop_front()), 32'(ch));
      chk({name, ".dat"}, q_dat.pop_front(), dat);
      chk({name, ".cyc"}, 32'(q_cyc.pop_front()), 32'(ec));
      chk({name, ".extra"}, 32'(q_dat.size()), 32'd0);
    end
  endtask

  task automatic expect_none(input string name);
    repeat (4) @(negedge clk);
    chk({name, ".nstrobe"}, 32'(q_dat.size()), 32'd0);
    q_dat.delete(); q_ch.delete(); q_cyc.delete();
  endtask

  task automatic chk_zero(input string name);
    chk({name, ".dat"}, smp.sample_dat, 32'd0);
    chk({name, ".ch"}, 32'(smp.sample_ch), 32'd0);
    chk({name, ".vld"}, 32'(smp.sample_vld), 32'd0);
    chk({name, ".locked"}, 32'(locked), 32'd0);
    chk({name, ".err"}, 32'(ferr), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 24'h5A5A5A, 4, 32'h005A5A5A};
    vecs[1] = '{1'b0, 24'h123456, 4, 32'h00123456};
    vecs[2] = '{1'b1, 24'hABCDEF, 4, 32'hFFABCDEF};
    vecs[3] = '{1'b0, 24'h800000, 4, 32'hFF800000};
    vecs[4] = '{1'b1, 24'h7FFFFF, 4, 32'h007FFFFF};
    vecs[5] = '{1'b0, 24'hFFFFFF, 4, 32'hFFFFFFFF};
    vecs[6] = '{1'b1, 24'h000001, 4, 32'h00000001};
    vecs[7] = '{1'b0, 24'h123456, 6, 32'h00123456};
    vecs[8] = '{1'b1, 24'hABCDEF, 6, 32'hFFABCDEF};

    repeat (5) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1; conf_en = 1'b1;
    repeat (2) @(negedge clk);

    // Lock on a WS edge; the slot that follows is the first captured one.
    repeat (3) send_bit(1'b0, 1'b0, 4);
    send_bit(1'b1, 1'b0, 4);
    repeat (2) @(negedge clk);
    chk("lock.locked", 32'(locked), 32'd1);

    for (int v = 0; v < 9; v++) begin
      send_slot(vecs[v].ch, vecs[v].data, vecs[v].half, 32);
      expect_strobe($sformatf("vec%0d", v), vecs[v].ch, vecs[v].exp);
    end
    chk("table.errs", 32'(err_cnt), 32'(exp_err));

    // Short slot: error, no strobe, stays locked, next slot still good.
    send_slot(1'b0, 24'h111111, 4, 16);
    exp_err++;
    expect_none("short");
    chk("short.errs", 32'(err_cnt), 32'(exp_err));
    chk("short.locked", 32'(locked), 32'd1);
    send_slot(1'b1, 24'h654321, 4, 32);
    expect_strobe("after_short", 1'b1, 32'h00654321);

    // Overlong slot drops lock; the next WS edge regains it.
    for (int i = 0; i < 70; i++) send_bit(1'b0, i[0], 4);
    exp_err++;
    expect_none("overlong");
    chk("overlong.errs", 32'(err_cnt), 32'(exp_err));
    chk("overlong.locked", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b0, 4);
    repeat (2) @(negedge clk);
    chk("relock.locked", 32'(locked), 32'd1);
    send_slot(1'b1, 24'hABCDEF, 4, 32);
    expect_strobe("after_overlong", 1'b1, 32'hFFABCDEF);

    // SCK loss.
    repeat (300) @(negedge clk);
    exp_err++;
    chk("timeout.errs", 32'(err_cnt), 32'(exp_err));
    chk("timeout.locked", 32'(locked), 32'd0);
    send_bit(1'b1, 1'b0, 4);
    send_slot(1'b1, 24'h123456, 4, 32);
    expect_strobe("after_timeout", 1'b1, 32'h00123456);

    // Enable dropped mid-slot: slot discarded silently.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, 4);
    conf_en = 1'b0;
    for (int i = 10; i < 32; i++) send_bit((i == 31) ? 1'b1 : 1'b0, 1'b1, 4);
    expect_none("disable");
    chk("disable.errs", 32'(err_cnt), 32'(exp_err));
    chk("disable.locked", 32'(locked), 32'd0);
    conf_en = 1'b1;
    send_slot(1'b1, 24'h222222, 4, 32);
    expect_none("reenable_lock");
    send_slot(1'b0, 24'h123456, 4, 32);
    expect_strobe("reenable_l", 1'b0, 32'h00123456);
    send_slot(1'b1, 24'hABCDEF, 4, 32);
    expect_strobe("reenable_r", 1'b1, 32'hFFABCDEF);

    // Reset pulse mid-slot.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, 4);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 10; i < 32; i++) send_bit((i == 31) ? 1'b1 : 1'b0, 1'b0, 4);
    expect_none("post_reset_lock");
    send_slot(1'b1, 24'hABCDEF, 4, 32);
    expect_strobe("post_reset", 1'b1, 32'hFFABCDEF);
    chk("final.errs", 32'(err_cnt), 32'(exp_err));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
